// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared constants and state encoding for the interrupt controller
//
// Purpose: register word offsets (selected by Addr[3:2]), FSM state encoding
// and the CLAIM "nothing pending" flag position, shared by int_controller and
// its testbench.
// Ports: none (package).

package intc_pkg;

  localparam logic [1:0] OFF_ENABLE  = 2'd0;
  localparam logic [1:0] OFF_PENDING = 2'd1;
  localparam logic [1:0] OFF_CLAIM   = 2'd2;
  localparam logic [1:0] OFF_EOI     = 2'd3;

  localparam int NONE_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - combinational priority encoder, lowest index wins
//
// Purpose: returns the index of the lowest set bit of req.
// Ports:
//   req   [N-1:0] in   request vector (bit 0 highest priority)
//   id    [2:0]   out  index of winning request (0 when none)
//   valid         out  1 when any request bit is set

module intc_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [2:0]   id,
  output logic         valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = 3'd0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - memory-mapped interrupt controller with claim/EOI handshake
//
// Purpose: latches rising edges of src_irq into PENDING, masks with ENABLE,
// picks the lowest-index source and drives a registered IRQ. Software claims
// the source (CLAIM write) and finishes with an EOI write carrying the id.
// Build option: INTC_LEVEL_TRIG_EN makes sources level-sensitive (PENDING
// reads the live src_irq, W1C and claim do not clear anything).
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   Addr     in   bus address, only Addr[3:2] decoded
//   WE       in   write strobe, already address-qualified
//   Din      in   write data
//   Dout     out  read data, combinational on Addr[3:2]
//   src_irq  in   raw interrupt sources, bit 0 highest priority
//   IRQ      out  registered interrupt request

module int_controller
  import intc_pkg::*;
#(
  parameter int          N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src_irq,
  output logic             IRQ
);

  logic [1:0]       reg_off;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] pend_vec;
  logic [N_SRC-1:0] pend_en;
  logic [2:0]       sel_id;
  logic             sel_valid;
  logic             claim_fire;
  state_t           state;
  logic [2:0]       claim_id;
  logic             irq_q;

  // The Bridge owns the full address decode; these bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Addr[1:0], Din[31:N_SRC], BASE_ADDR};

  assign reg_off = Addr[3:2];
  assign pend_en = pend_vec & enable_q;
  assign IRQ     = irq_q;

  intc_prio_enc #(.N(N_SRC)) u_prio_enc (
    .req   (pend_en),
    .id    (sel_id),
    .valid (sel_valid)
  );

  // A claim only counts while asserting and with something to hand out.
  assign claim_fire = WE && (reg_off == OFF_CLAIM) && (state == ASSERT) && sel_valid;

`ifdef INTC_LEVEL_TRIG_EN
  assign pend_vec = src_irq;
`else
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] w1c_mask;
  logic [N_SRC-1:0] claim_mask;

  assign pend_vec   = pending_q;
  assign w1c_mask   = (WE && (reg_off == OFF_PENDING)) ? Din[N_SRC-1:0] : '0;
  assign claim_mask = claim_fire ? (N_SRC'(1) << sel_id) : '0;

  // New edges are OR-ed in after the clears so a coincident set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      src_d     <= '0;
    end else begin
      src_d     <= src_irq;
      pending_q <= (pending_q & ~w1c_mask & ~claim_mask) | (src_irq & ~src_d);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
    end else if (WE && (reg_off == OFF_ENABLE)) begin
      enable_q <= Din[N_SRC-1:0];
    end
  end

  // IRQ is registered alongside the state so it is high exactly in ASSERT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      claim_id <= 3'd0;
      irq_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state <= ASSERT;
            irq_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (claim_fire) begin
            claim_id <= sel_id;
            state    <= SERVICE;
            irq_q    <= 1'b0;
          end else if (!sel_valid) begin
            state <= IDLE;
            irq_q <= 1'b0;
          end
        end
        SERVICE: begin
          irq_q <= 1'b0;
          if (WE && (reg_off == OFF_EOI) && (Din[2:0] == claim_id)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (reg_off)
      OFF_ENABLE:  Dout[N_SRC-1:0] = enable_q;
      OFF_PENDING: Dout[N_SRC-1:0] = pend_vec;
      OFF_CLAIM: begin
        if (sel_valid) Dout[2:0] = sel_id;
        else           Dout[NONE_BIT] = 1'b1;
      end
      default: begin
        Dout[9:8] = state;
        Dout[2:0] = claim_id;
      end
    endcase
  end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - testbench for int_controller (edge-triggered build)

module tb_int_controller;

  localparam int          N    = 6;
  localparam logic [31:0] BASE = 32'h0000_7F20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   Addr = BASE;
  logic          WE = 1'b0;
  logic [31:0]   Din = 32'd0;
  logic [31:0]   Dout;
  logic [N-1:0]  src_irq = '0;
  logic          IRQ;

  int checks = 0;
  int failures = 0;

  // Reference model: what software should observe.
  bit [N-1:0] m_en, m_pend, m_prev;
  int         m_phase;   // 0 idle, 1 requesting, 2 being serviced (STATUS[9:8] value)
  int         m_cid;
  bit         m_irq;

  int_controller #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .src_irq (src_irq),
    .IRQ     (IRQ)
  );

  always #10 clk = ~clk;

  function automatic int best_source();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_read(input int off);
    int b;
    case (off)
      0: return 32'(m_en);
      1: return 32'(m_pend);
      2: begin
        b = best_source();
        return (b < 0) ? 32'h8000_0000 : 32'(b);
      end
      default: return 32'((m_phase * 256) + m_cid);
    endcase
  endfunction

  // One clock cycle: drive inputs on the falling edge, advance the model,
  // then release WE shortly after the rising edge.
  task automatic step(input bit rst, input bit [N-1:0] src, input bit we_i,
                      input int off, input logic [31:0] din_i);
    bit [N-1:0] n_en, n_pend, clr, w1c;
    int n_phase, n_cid, b;
    @(negedge clk);
    reset = rst; src_irq = src; WE = we_i; Din = din_i;
    Addr = BASE + 32'(off * 4);
    if (rst) begin
      n_en = '0; n_pend = '0; n_phase = 0; n_cid = 0;
    end else begin
      b = best_source();
      n_en = (we_i && off == 0) ? din_i[N-1:0] : m_en;
      w1c = (we_i && off == 1) ? din_i[N-1:0] : '0;
      clr = '0;
      n_phase = m_phase; n_cid = m_cid;
      if (m_phase == 0) begin
        if (b >= 0) n_phase = 1;
      end else if (m_phase == 1) begin
        if (we_i && off == 2 && b >= 0) begin
          n_cid = b; clr[b] = 1'b1; n_phase = 2;
        end else if (b < 0) n_phase = 0;
      end else begin
        if (we_i && off == 3 && int'(din_i[2:0]) == m_cid) n_phase = 0;
      end
      n_pend = (m_pend & ~w1c & ~clr) | (src & ~m_prev);
    end
    @(posedge clk);
    m_en = n_en; m_pend = n_pend; m_phase = n_phase; m_cid = n_cid;
    m_prev = rst ? '0 : src;
    m_irq = (n_phase == 1);
    #1;
    WE = 1'b0; reset = 1'b0;
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    Addr = BASE + 32'(off * 4);
    #1;
    d = Dout;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, src_irq, 1'b0, 0, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    step(1'b1, '0, 1'b0, 0, 32'd0);
    for (int off = 0; off < 4; off++) begin
      rd(off, d);
      checks++;
      if (d !== exp_read(off)) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h expected %h", off, d, exp_read(off));
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
  endtask

  task automatic test_single_pulse();
    logic [31:0] d;
    step(1'b0, '0, 1'b1, 0, 32'h3);
    step(1'b0, 6'b000001, 1'b0, 0, 32'd0);
    rd(1, d);
    checks++;
    if (d !== 32'h1 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL pulse_first_edge: pending %h irq %b expected 1 / 0", d, IRQ);
    end
    step(1'b0, 6'b000000, 1'b0, 0, 32'd0);
    rd(2, d);
    checks++;
    if (IRQ !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL pulse_irq_claim: irq %b claim %h expected 1 / 0", IRQ, d);
    end
    step(1'b0, '0, 1'b1, 2, 32'd0);
    rd(3, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'h200) begin
      failures++;
      $display("FAIL pulse_claimed: irq %b status %h expected 0 / 200", IRQ, d);
    end
    step(1'b0, '0, 1'b1, 3, 32'd0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    step(1'b0, 6'b000011, 1'b0, 0, 32'd0);
    step(1'b0, 6'b000011, 1'b0, 0, 32'd0);
    rd(2, d);
    checks++;
    if (d !== 32'h0 || IRQ !== 1'b1) begin
      failures++;
      $display("FAIL simul_claim0: claim %h irq %b expected 0 / 1", d, IRQ);
    end
    step(1'b0, 6'b000011, 1'b1, 2, 32'd0);
    step(1'b0, 6'b000011, 1'b1, 3, 32'd0);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL simul_after_eoi: irq %b expected 0", IRQ);
    end
    step(1'b0, 6'b000000, 1'b0, 0, 32'd0);
    rd(2, d);
    checks++;
    if (IRQ !== 1'b1 || d !== 32'h1) begin
      failures++;
      $display("FAIL simul_reassert: irq %b claim %h expected 1 / 1", IRQ, d);
    end
  endtask

  task automatic test_eoi_mismatch();
    logic [31:0] d;
    step(1'b0, '0, 1'b1, 2, 32'd0);
    step(1'b0, '0, 1'b1, 3, 32'd3);
    rd(3, d);
    checks++;
    if (d !== 32'h201) begin
      failures++;
      $display("FAIL eoi_mismatch: status %h expected 201", d);
    end
    step(1'b0, '0, 1'b1, 3, 32'd1);
    rd(3, d);
    checks++;
    if (d !== 32'h001 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL eoi_match: status %h irq %b expected 001 / 0", d, IRQ);
    end
  endtask

  task automatic test_masked();
    logic [31:0] d;
    step(1'b0, 6'b000100, 1'b0, 0, 32'd0);
    idle(3);
    rd(1, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'h4) begin
      failures++;
      $display("FAIL masked_hold: irq %b pending %h expected 0 / 4", IRQ, d);
    end
    step(1'b0, 6'b000100, 1'b1, 0, 32'h4);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL masked_enable_write: irq %b expected 0", IRQ);
    end
    step(1'b0, 6'b000000, 1'b0, 0, 32'd0);
    checks++;
    if (IRQ !== 1'b1) begin
      failures++;
      $display("FAIL masked_enabled: irq %b expected 1", IRQ);
    end
    step(1'b0, '0, 1'b1, 2, 32'd0);
    step(1'b0, '0, 1'b1, 3, 32'd2);
  endtask

  task automatic test_w1c_vs_edge();
    logic [31:0] d;
    step(1'b0, 6'b001000, 1'b1, 1, 32'h8);
    rd(1, d);
    checks++;
    if (d[3] !== 1'b1) begin
      failures++;
      $display("FAIL w1c_set_wins: pending %h expected bit3 set", d);
    end
    step(1'b0, 6'b001000, 1'b1, 1, 32'h8);
    rd(1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL w1c_clear: pending %h expected 0", d);
    end
  endtask

  task automatic test_reset_in_service();
    logic [31:0] d;
    step(1'b0, 6'b000000, 1'b1, 0, 32'h1);
    step(1'b0, 6'b000001, 1'b0, 0, 32'd0);
    step(1'b0, 6'b000001, 1'b0, 0, 32'd0);
    step(1'b0, 6'b000001, 1'b1, 2, 32'd0);
    step(1'b0, 6'b101001, 1'b0, 0, 32'd0);
    rd(1, d);
    checks++;
    if (d !== 32'h28) begin
      failures++;
      $display("FAIL service_pending: pending %h expected 28", d);
    end
    rd(3, d);
    checks++;
    if (d !== 32'h200) begin
      failures++;
      $display("FAIL service_status: status %h expected 200", d);
    end
    step(1'b1, 6'b101001, 1'b0, 0, 32'd0);
    for (int off = 0; off < 4; off++) begin
      rd(off, d);
      checks++;
      if (off != 2 && d !== 32'h0) begin
        failures++;
        $display("FAIL midreset_reg%0d: got %h expected 0", off, d);
      end else if (off == 2 && d !== 32'h8000_0000) begin
        failures++;
        $display("FAIL midreset_claim: got %h expected 80000000", d);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL midreset_irq: got %b expected 0", IRQ);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    bit [N-1:0]  src;
    int          off, r;
    logic [31:0] din_r;
    for (int n = 0; n < 400; n++) begin
      src = src_irq;
      if ($urandom_range(0, 3) == 0) src = N'($urandom);
      r = $urandom_range(0, 9);
      off = $urandom_range(0, 3);
      din_r = $urandom;
      if (off == 3 && $urandom_range(0, 1) == 1) din_r = 32'(m_cid);
      step((r == 0 && $urandom_range(0, 7) == 0), src, (r < 4), off, din_r);
      for (int k = 0; k < 4; k++) begin
        rd(k, d);
        checks++;
        if (d !== exp_read(k)) begin
          failures++;
          $display("FAIL random_reg%0d cycle %0d: got %h expected %h", k, n, d, exp_read(k));
        end
      end
      checks++;
      if (IRQ !== m_irq) begin
        failures++;
        $display("FAIL random_irq cycle %0d: got %b expected %b", n, IRQ, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_simultaneous();
    test_eoi_mismatch();
    test_masked();
    test_w1c_vs_edge();
    test_reset_in_service();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
